// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: register map, ap_ctrl bit positions and sequencer states for fir_ctrl.
package fir_ctrl_pkg;
    localparam logic [31:0] ADDR_AP_CTRL  = 32'h00;
    localparam logic [31:0] ADDR_DATA_LEN = 32'h10;
    localparam logic [31:0] ADDR_TAP_BASE = 32'h80;
    localparam int AP_START = 0;
    localparam int AP_DONE  = 1;
    localparam int AP_IDLE  = 2;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    function automatic logic is_tap(input logic [31:0] a, input int n);
        return a >= ADDR_TAP_BASE && a <= ADDR_TAP_BASE + 32'(4 * (n - 1));
    endfunction
endpackage

// File: rtl/fir_ctrl_if.sv
// fir_ctrl_if: AXI-Lite configuration bus; master drives requests, slave is fir_ctrl.
interface fir_ctrl_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid, awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid, wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid, arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid, rready;
    logic [pDATA_WIDTH-1:0] rdata;
    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );
    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/fir_tap_arb.sv
// fir_tap_arb: tap BRAM port mux between AXI-Lite and the engine, plus the AXI read-return path.
module fir_tap_arb
    import fir_ctrl_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   i_run,
    input  logic                   i_wr_hs,
    input  logic                   i_wr_tap,
    input  logic [pADDR_WIDTH-1:0] i_awaddr,
    input  logic [pDATA_WIDTH-1:0] i_wdata,
    input  logic                   i_rd_hs,
    input  logic                   i_rd_tap,
    input  logic [pADDR_WIDTH-1:0] i_araddr,
    input  logic [pDATA_WIDTH-1:0] i_reg_rd,
    input  logic                   i_rready,
    input  logic                   i_eng_tap_req,
    input  logic [pADDR_WIDTH-1:0] i_eng_tap_A,
    input  logic [pDATA_WIDTH-1:0] i_tap_Do,
    output logic                   o_rvalid,
    output logic [pDATA_WIDTH-1:0] o_rdata,
    output logic [3:0]             o_tap_WE,
    output logic                   o_tap_EN,
    output logic [pDATA_WIDTH-1:0] o_tap_Di,
    output logic [pADDR_WIDTH-1:0] o_tap_A
);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE = pADDR_WIDTH'(ADDR_TAP_BASE);
    logic                   w_axi_wr, w_axi_rd;
    logic                   r_rvalid, r_tap_pend;
    logic [pDATA_WIDTH-1:0] r_rdata;
    assign w_axi_wr = !i_run && i_wr_hs && i_wr_tap;
    assign w_axi_rd = !i_run && i_rd_hs && i_rd_tap;
    always_comb begin
        o_tap_EN = i_run ? i_eng_tap_req : w_axi_wr || w_axi_rd;
        o_tap_WE = w_axi_wr ? 4'hf : 4'h0;
        o_tap_A  = i_run ? i_eng_tap_A : w_axi_wr ? i_awaddr - TAP_BASE : w_axi_rd ? i_araddr - TAP_BASE : '0;
        o_tap_Di = w_axi_wr ? i_wdata : '0;
    end
    // BRAM data is passed straight through the cycle rvalid rises, then captured so it holds until rready.
    always_ff @(posedge axis_clk or negedge axis_rst_n)
        if (!axis_rst_n) begin
            r_rvalid   <= 1'b0;
            r_tap_pend <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rvalid   <= i_rd_hs || (r_rvalid && !i_rready);
            r_tap_pend <= w_axi_rd;
            r_rdata    <= r_tap_pend ? i_tap_Do : !i_rd_hs ? r_rdata : !i_rd_tap ? i_reg_rd : '1;
        end
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_tap_pend ? i_tap_Do : r_rdata;
endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: AXI-Lite config registers, ap_ctrl idle/run/done sequencer and tap BRAM ownership.
// Define FIR_CTRL_DONE_COR_EN to make ap_done clear when ap_ctrl is read.
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    fir_ctrl_if.slave              s_axi,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   eng_tap_req,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    input  logic                   eng_done,
    output logic                   eng_start,
    output logic                   eng_run,
    output logic [31:0]            data_length
);
    state_t                 r_state;
    logic                   r_wr_rdy, r_ar_rdy;
    logic                   r_eng_start, r_eng_run, r_ap_done, r_ap_idle;
    logic [31:0]            r_data_length;
    logic                   w_wr_next, w_wr_hs, w_rd_hs, w_rvalid, w_start;
    logic [pDATA_WIDTH-1:0] w_ctrl, w_reg_rd;
    assign w_wr_next = s_axi.awvalid && s_axi.wvalid && !r_wr_rdy;
    assign w_wr_hs   = r_wr_rdy && s_axi.awvalid && s_axi.wvalid;
    assign w_rd_hs   = r_ar_rdy && s_axi.arvalid;
    assign w_start   = w_wr_hs && s_axi.awaddr == pADDR_WIDTH'(ADDR_AP_CTRL) && s_axi.wdata[AP_START];
    always_comb begin
        w_ctrl           = '0;
        w_ctrl[AP_START] = r_eng_start;
        w_ctrl[AP_DONE]  = r_ap_done;
        w_ctrl[AP_IDLE]  = r_ap_idle;
        w_reg_rd = s_axi.araddr == pADDR_WIDTH'(ADDR_AP_CTRL) ? w_ctrl :
                   s_axi.araddr == pADDR_WIDTH'(ADDR_DATA_LEN) ? pDATA_WIDTH'(r_data_length) : '0;
    end
    // arready stays low in any cycle that will carry a write handshake, so writes win.
    always_ff @(posedge axis_clk or negedge axis_rst_n)
        if (!axis_rst_n) begin
            r_wr_rdy      <= 1'b0;
            r_ar_rdy      <= 1'b0;
            r_data_length <= '0;
        end else begin
            r_wr_rdy <= w_wr_next;
            r_ar_rdy <= s_axi.arvalid && !w_rvalid && !r_ar_rdy && !w_wr_next;
            if (w_wr_hs && s_axi.awaddr == pADDR_WIDTH'(ADDR_DATA_LEN))
                r_data_length <= 32'(s_axi.wdata);
        end
`ifdef FIR_CTRL_DONE_COR_EN
    logic r_rd_ctrl;
    always_ff @(posedge axis_clk or negedge axis_rst_n)
        if (!axis_rst_n)
            r_rd_ctrl <= 1'b0;
        else if (w_rd_hs)
            r_rd_ctrl <= s_axi.araddr == pADDR_WIDTH'(ADDR_AP_CTRL);
`endif
    always_ff @(posedge axis_clk or negedge axis_rst_n)
        if (!axis_rst_n) begin
            r_state     <= S_IDLE;
            r_eng_start <= 1'b0;
            r_eng_run   <= 1'b0;
            r_ap_done   <= 1'b0;
            r_ap_idle   <= 1'b1;
        end else begin
            r_eng_start <= 1'b0;
`ifdef FIR_CTRL_DONE_COR_EN
            if (r_rd_ctrl && w_rvalid && s_axi.rready)
                r_ap_done <= 1'b0;
`endif
            case (r_state)
                S_IDLE:
                    if (w_start) begin
                        r_state     <= S_RUN;
                        r_eng_start <= 1'b1;
                        r_eng_run   <= 1'b1;
                        r_ap_idle   <= 1'b0;
                        r_ap_done   <= 1'b0;
                    end
                S_RUN:
                    if (eng_done) begin
                        r_state   <= S_DONE;
                        r_eng_run <= 1'b0;
                        r_ap_done <= 1'b1;
                        r_ap_idle <= 1'b1;
                    end
                default: r_state <= S_IDLE;
            endcase
        end
    fir_tap_arb #(.pADDR_WIDTH(pADDR_WIDTH), .pDATA_WIDTH(pDATA_WIDTH)) u_arb (
        .axis_clk      (axis_clk),
        .axis_rst_n    (axis_rst_n),
        .i_run         (r_eng_run),
        .i_wr_hs       (w_wr_hs),
        .i_wr_tap      (is_tap(32'(s_axi.awaddr), Tape_Num)),
        .i_awaddr      (s_axi.awaddr),
        .i_wdata       (s_axi.wdata),
        .i_rd_hs       (w_rd_hs),
        .i_rd_tap      (is_tap(32'(s_axi.araddr), Tape_Num)),
        .i_araddr      (s_axi.araddr),
        .i_reg_rd      (w_reg_rd),
        .i_rready      (s_axi.rready),
        .i_eng_tap_req (eng_tap_req),
        .i_eng_tap_A   (eng_tap_A),
        .i_tap_Do      (tap_Do),
        .o_rvalid      (w_rvalid),
        .o_rdata       (s_axi.rdata),
        .o_tap_WE      (tap_WE),
        .o_tap_EN      (tap_EN),
        .o_tap_Di      (tap_Di),
        .o_tap_A       (tap_A)
    );
    assign s_axi.awready = r_wr_rdy;
    assign s_axi.wready  = r_wr_rdy;
    assign s_axi.arready = r_ar_rdy;
    assign s_axi.rvalid  = w_rvalid;
    assign eng_start     = r_eng_start;
    assign eng_run       = r_eng_run;
    assign data_length   = r_data_length;
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed AXI-Lite sequence against fir_ctrl with a behavioural tap BRAM and engine stub.
module tb_fir_ctrl;
    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di, tap_Do;
    logic [11:0] tap_A;
    logic        eng_tap_req = 1'b0;
    logic [11:0] eng_tap_A = '0;
    logic        eng_done = 1'b0;
    logic        eng_start, eng_run;
    logic [31:0] data_length;
    logic [31:0] mem [0:1023];
    logic [31:0] rd_d;
    logic [1:0]  rd_v;
    logic [31:0] exp_again;
    int          total = 0;
    int          bad = 0;
    int          taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    fir_ctrl_if bus ();

    fir_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .s_axi       (bus),
        .tap_WE      (tap_WE),
        .tap_EN      (tap_EN),
        .tap_Di      (tap_Di),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .eng_tap_req (eng_tap_req),
        .eng_tap_A   (eng_tap_A),
        .eng_done    (eng_done),
        .eng_start   (eng_start),
        .eng_run     (eng_run),
        .data_length (data_length)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk)
        if (tap_EN) begin
            for (int b = 0; b < 4; b++)
                if (tap_WE[b]) mem[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
            tap_Do <= mem[tap_A[11:2]];
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge axis_clk);
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = a; bus.wdata = d;
        while (!(bus.awready && bus.wready) && n < 20) begin @(negedge axis_clk); n++; end
        check("wr handshake", 32'(n < 20), 32'd1);
        @(negedge axis_clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] rv);
        int n = 0;
        @(negedge axis_clk);
        bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b1;
        while (!bus.arready && n < 20) begin @(negedge axis_clk); n++; end
        check("rd handshake", 32'(n < 20), 32'd1);
        rv[1] = bus.rvalid;
        @(negedge axis_clk);
        bus.arvalid = 1'b0;
        rv[0] = bus.rvalid;
        d = bus.rdata;
        @(negedge axis_clk);
        bus.rready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  rv;
        axi_read(a, d, rv);
        check(tag, d, exp);
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.wdata = '0; bus.araddr = '0;
`ifdef FIR_CTRL_DONE_COR_EN
        exp_again = 32'h4;
`else
        exp_again = 32'h6;
`endif
        repeat (3) @(negedge axis_clk);
        check("rst ready/valid", {28'd0, bus.awready, bus.wready, bus.arready, bus.rvalid}, 32'd0);
        check("rst rdata", bus.rdata, 32'd0);
        check("rst tap ctl", {20'd0, tap_EN, tap_WE, 7'd0}, 32'd0);
        check("rst tap_A/Di", tap_Di | 32'(tap_A), 32'd0);
        check("rst eng", {30'd0, eng_start, eng_run}, 32'd0);
        check("rst data_length", data_length, 32'd0);
        axis_rst_n = 1'b1;

        rd_check("ap_ctrl after rst", 12'h000, 32'h4);
        rd_check("data_length after rst", 12'h010, 32'h0);

        axi_write(12'h010, 32'd600);
        check("data_length port", data_length, 32'd600);
        rd_check("data_length rd", 12'h010, 32'd600);
        for (int i = 0; i < 11; i++) axi_write(12'(32'h80 + 4 * i), 32'(taps[i]));
        for (int i = 0; i < 11; i++) begin
            axi_read(12'(32'h80 + 4 * i), rd_d, rd_v);
            check($sformatf("tap%0d", i), rd_d, 32'(taps[i]));
            check($sformatf("tap%0d rvalid timing", i), 32'(rd_v), 32'd1);
        end
        axi_write(12'h0AC, 32'd77);
        rd_check("past last tap", 12'h0AC, 32'h0);
        axi_write(12'h020, 32'd5);
        rd_check("unmapped", 12'h020, 32'h0);

        eng_tap_req = 1'b1; eng_tap_A = 12'h008;
        @(negedge axis_clk);
        check("idle ignores eng req", 32'(tap_EN), 32'd0);
        eng_tap_req = 1'b0;
        axi_write(12'h000, 32'h0);
        check("write 0 no start", {30'd0, eng_start, eng_run}, 32'd0);
        rd_check("ap_ctrl after write 0", 12'h000, 32'h4);

        axi_write(12'h000, 32'h1);
        check("start pulse", {30'd0, eng_start, eng_run}, 32'd3);
        @(negedge axis_clk);
        check("start one cycle", {30'd0, eng_start, eng_run}, 32'd1);
        rd_check("ap_ctrl in run", 12'h000, 32'h0);
        eng_tap_req = 1'b1; eng_tap_A = 12'h008;
        #1;
        check("run eng owns port", {15'd0, tap_EN, tap_WE, tap_A}, {15'd0, 1'b1, 4'h0, 12'h008});
        @(negedge axis_clk);
        eng_tap_req = 1'b0;
        axi_write(12'h084, 32'd99);
        axi_write(12'h000, 32'h1);
        check("start ignored in run", 32'(eng_start), 32'd0);
        rd_check("tap read in run", 12'h084, 32'hFFFF_FFFF);

        @(negedge axis_clk);
        eng_done = 1'b1;
        @(negedge axis_clk);
        eng_done = 1'b0;
        check("eng_run after done", 32'(eng_run), 32'd0);
        rd_check("ap_ctrl done", 12'h000, 32'h6);
        rd_check("ap_ctrl again", 12'h000, exp_again);
        rd_check("tap write discarded", 12'h084, 32'hFFFF_FFF6);
        @(negedge axis_clk);
        eng_done = 1'b1;
        @(negedge axis_clk);
        eng_done = 1'b0;
        rd_check("done ignored in idle", 12'h000, exp_again);

        axi_write(12'h000, 32'h1);
        check("second start", 32'(eng_run), 32'd1);
        repeat (3) @(negedge axis_clk);
        #2 axis_rst_n = 1'b0;
        #1;
        check("rst mid-run eng", {30'd0, eng_start, eng_run}, 32'd0);
        check("rst mid-run ready", {30'd0, bus.awready, bus.rvalid}, 32'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        rd_check("ap_ctrl after rst2", 12'h000, 32'h4);
        rd_check("data_length after rst2", 12'h010, 32'h0);
        rd_check("tap0 kept", 12'h080, 32'h0);
        rd_check("tap1 kept", 12'h084, 32'hFFFF_FFF6);
        rd_check("tap5 kept", 12'h094, 32'd63);
        rd_check("tap10 kept", 12'h0A8, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
